// File: rtl/adder_check_pkg.sv
// Shared constants and types for the adder stimulus/checker block.
package adder_check_pkg;

    // Number of fixed corner vectors issued before the random phase.
    localparam int unsigned CORNER_COUNT = 5;

    // Fibonacci taps for x^32 + x^22 + x^2 + x + 1 (bit i = exponent i+1).
    localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED = 32'hACE1_2025;

    // State encodings kept as plain constants so legacy code can compare against them.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CORNER = 2'd1;
    localparam logic [1:0] ST_RANDOM = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef enum logic [1:0] {
        CHK_IDLE   = ST_IDLE,
        CHK_CORNER = ST_CORNER,
        CHK_RANDOM = ST_RANDOM,
        CHK_DONE   = ST_DONE
    } chk_state_t;

endpackage

// File: rtl/adder_stim_checker_lfsr.sv
// 32-bit Fibonacci LFSR: loads the seed on request, advances one step when enabled.
module adder_lfsr32
    import adder_check_pkg::*;
#(
    parameter logic [31:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    output logic [31:0] state
);

    logic feedback_c;

    // Feedback is the XOR of all tapped bits.
    always_comb begin
        feedback_c = ^(state & LFSR_TAPS);
    end

    // Load takes priority over step so a run always begins at the seed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (load) begin
            state <= SEED;
        end else if (step) begin
            state <= {state[30:0], feedback_c};
        end
    end

endmodule

// File: rtl/adder_stim_checker.sv
// Drives corner and pseudo-random operand vectors into a combinational adder,
// checks each returned sum one cycle later and reports counts and first failure.
module adder_stim_checker
    import adder_check_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned NUM_RANDOM = 100,
    parameter logic [31:0] LFSR_SEED  = DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    input  logic [WIDTH:0]   sum_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      vec_count,
    output logic [15:0]      error_count,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic [WIDTH:0]   fail_sum
);

    localparam logic [WIDTH-1:0] MAX_V       = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_V       = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO_V      = '0;
    localparam logic [2:0]       CORNER_LAST = 3'(CORNER_COUNT - 1);
    localparam bit               HAS_RANDOM  = (NUM_RANDOM != 0);
    localparam logic [15:0]      RND_LAST    = 16'((NUM_RANDOM == 0) ? 0 : NUM_RANDOM - 1);

    chk_state_t       state_q, state_d;
    logic [2:0]       cidx_q, cidx_d;
    logic [15:0]      rleft_q, rleft_d;
    logic [WIDTH-1:0] op_a_d, op_b_d;
    logic             busy_d, done_d, pass_d;
    logic [15:0]      vec_count_d, error_count_d;
    logic [WIDTH-1:0] fail_a_d, fail_b_d;
    logic [WIDTH:0]   fail_sum_d;

    logic             lfsr_load_c, lfsr_step_c;
    logic [31:0]      lfsr_q;
    logic             unused_lfsr_bits;
    logic [WIDTH:0]   exp_sum_c;
    logic             mismatch_c;
    logic             check_c;
    logic             finish_c;

    adder_lfsr32 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load_c),
        .step  (lfsr_step_c),
        .state (lfsr_q)
    );

    // Upper LFSR bits beyond two operands are intentionally not used.
    assign unused_lfsr_bits = ^lfsr_q;

    function automatic logic [WIDTH-1:0] corner_a(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1: corner_a = ZERO_V;
            default:    corner_a = MAX_V;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] corner_b(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd2: corner_b = ZERO_V;
            3'd4:       corner_b = ONE_V;
            default:    corner_b = MAX_V;
        endcase
    endfunction

    // Full-width reference sum; 4-state compare so X/Z on the adder counts as an error.
    always_comb begin
        exp_sum_c  = {1'b0, op_a} + {1'b0, op_b};
        mismatch_c = (sum_in !== exp_sum_c);
    end

    // Next-state, vector sequencing, checking and result registers.
    always_comb begin
        state_d       = state_q;
        cidx_d        = cidx_q;
        rleft_d       = rleft_q;
        op_a_d        = op_a;
        op_b_d        = op_b;
        busy_d        = busy;
        done_d        = done;
        pass_d        = pass;
        vec_count_d   = vec_count;
        error_count_d = error_count;
        fail_a_d      = fail_a;
        fail_b_d      = fail_b;
        fail_sum_d    = fail_sum;
        lfsr_load_c   = 1'b0;
        lfsr_step_c   = 1'b0;
        finish_c      = 1'b0;

        check_c = (state_q == CHK_CORNER) || (state_q == CHK_RANDOM);

        if (check_c) begin
            vec_count_d = vec_count + 16'd1;
            if (mismatch_c) begin
                if (error_count != 16'hFFFF) begin
                    error_count_d = error_count + 16'd1;
                end
                if (error_count == 16'd0) begin
                    fail_a_d   = op_a;
                    fail_b_d   = op_b;
                    fail_sum_d = sum_in;
                end
            end
        end

        case (state_q)
            CHK_IDLE, CHK_DONE: begin
                if (start) begin
                    state_d       = CHK_CORNER;
                    cidx_d        = 3'd0;
                    rleft_d       = 16'd0;
                    op_a_d        = corner_a(3'd0);
                    op_b_d        = corner_b(3'd0);
                    busy_d        = 1'b1;
                    done_d        = 1'b0;
                    pass_d        = 1'b0;
                    vec_count_d   = 16'd0;
                    error_count_d = 16'd0;
                    fail_a_d      = '0;
                    fail_b_d      = '0;
                    fail_sum_d    = '0;
                    lfsr_load_c   = 1'b1;
                end
            end
            CHK_CORNER: begin
                if (cidx_q != CORNER_LAST) begin
                    cidx_d = cidx_q + 3'd1;
                    op_a_d = corner_a(cidx_q + 3'd1);
                    op_b_d = corner_b(cidx_q + 3'd1);
                end else if (HAS_RANDOM) begin
                    state_d     = CHK_RANDOM;
                    rleft_d     = RND_LAST;
                    op_a_d      = lfsr_q[WIDTH-1:0];
                    op_b_d      = lfsr_q[2*WIDTH-1:WIDTH];
                    lfsr_step_c = 1'b1;
                end else begin
                    finish_c = 1'b1;
                end
            end
            CHK_RANDOM: begin
                if (rleft_q == 16'd0) begin
                    finish_c = 1'b1;
                end else begin
                    rleft_d     = rleft_q - 16'd1;
                    op_a_d      = lfsr_q[WIDTH-1:0];
                    op_b_d      = lfsr_q[2*WIDTH-1:WIDTH];
                    lfsr_step_c = 1'b1;
                end
            end
            default: begin
                state_d = CHK_IDLE;
            end
        endcase

        if (finish_c) begin
            state_d = CHK_DONE;
            op_a_d  = '0;
            op_b_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (error_count_d == 16'd0);
        end
    end

    // State and all registered outputs; reset clears every partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CHK_IDLE;
            cidx_q      <= 3'd0;
            rleft_q     <= 16'd0;
            op_a        <= '0;
            op_b        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            vec_count   <= 16'd0;
            error_count <= 16'd0;
            fail_a      <= '0;
            fail_b      <= '0;
            fail_sum    <= '0;
        end else begin
            state_q     <= state_d;
            cidx_q      <= cidx_d;
            rleft_q     <= rleft_d;
            op_a        <= op_a_d;
            op_b        <= op_b_d;
            busy        <= busy_d;
            done        <= done_d;
            pass        <= pass_d;
            vec_count   <= vec_count_d;
            error_count <= error_count_d;
            fail_a      <= fail_a_d;
            fail_b      <= fail_b_d;
            fail_sum    <= fail_sum_d;
        end
    end

endmodule

// File: tb/tb_adder_stim_checker.sv
// Bench for adder_stim_checker: one instance with 100 random vectors (golden or
// faulty adder), one with no random vectors; a vector-list model is compared every cycle.
module tb_adder_stim_checker;

    localparam int NV0 = 105;
    localparam int NV1 = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start0, start1, fault;

    logic [7:0]  a0, b0, fa0, fb0, a1, b1, fa1, fb1;
    logic [8:0]  s0, fs0, s1, fs1;
    logic        busy0, done0, pass0, busy1, done1, pass1;
    logic [15:0] vc0, ec0, vc1, ec1;

    // Adder for instance 0 can have its carry-out stuck at 0.
    assign s0 = fault ? {1'b0, 8'(a0 + b0)} : ({1'b0, a0} + {1'b0, b0});
    assign s1 = {1'b0, a1} + {1'b0, b1};

    adder_stim_checker #(.WIDTH(8), .NUM_RANDOM(100), .LFSR_SEED(32'hACE1_2025)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .op_a(a0), .op_b(b0), .sum_in(s0),
        .busy(busy0), .done(done0), .pass(pass0), .vec_count(vc0), .error_count(ec0),
        .fail_a(fa0), .fail_b(fb0), .fail_sum(fs0));

    adder_stim_checker #(.WIDTH(8), .NUM_RANDOM(0), .LFSR_SEED(32'hACE1_2025)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op_a(a1), .op_b(b1), .sum_in(s1),
        .busy(busy1), .done(done1), .pass(pass1), .vec_count(vc1), .error_count(ec1),
        .fail_a(fa1), .fail_b(fb1), .fail_sum(fs1));

    int n_vec = 0;
    int n_err = 0;

    task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected vector lists, built from the corner table and the LFSR polynomial.
    logic [7:0] va [2][NV0];
    logic [7:0] vb [2][NV0];
    int         nvec [2];
    logic [15:0] ctab [5];

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    // Model state: which vector is on the outputs plus expected results.
    logic       m_busy [2];
    logic       m_done [2];
    logic       m_pass [2];
    int         m_k    [2];
    int         m_vec  [2];
    int         m_err  [2];
    logic [7:0] m_fa   [2];
    logic [7:0] m_fb   [2];
    logic [8:0] m_fs   [2];

    always @(posedge clk or negedge rst_n) begin
        logic [7:0] ea, eb;
        logic [8:0] got, ideal;
        logic       st;
        int         nerr;
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_busy[d] <= 1'b0; m_done[d] <= 1'b0; m_pass[d] <= 1'b0;
                m_k[d] <= 0; m_vec[d] <= 0; m_err[d] <= 0;
                m_fa[d] <= '0; m_fb[d] <= '0; m_fs[d] <= '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                st = (d == 0) ? start0 : start1;
                if (m_busy[d]) begin
                    ea    = va[d][m_k[d]];
                    eb    = vb[d][m_k[d]];
                    ideal = {1'b0, ea} + {1'b0, eb};
                    got   = (d == 0 && fault) ? {1'b0, 8'(ea + eb)} : ideal;
                    nerr  = m_err[d];
                    if (got != ideal) begin
                        if (nerr == 0) begin
                            m_fa[d] <= ea; m_fb[d] <= eb; m_fs[d] <= got;
                        end
                        if (nerr < 65535) nerr = nerr + 1;
                    end
                    m_err[d] <= nerr;
                    m_vec[d] <= m_vec[d] + 1;
                    if (m_k[d] == nvec[d] - 1) begin
                        m_busy[d] <= 1'b0; m_done[d] <= 1'b1;
                        m_pass[d] <= (nerr == 0); m_k[d] <= 0;
                    end else begin
                        m_k[d] <= m_k[d] + 1;
                    end
                end else if (st) begin
                    m_busy[d] <= 1'b1; m_done[d] <= 1'b0; m_pass[d] <= 1'b0;
                    m_k[d] <= 0; m_vec[d] <= 0; m_err[d] <= 0;
                    m_fa[d] <= '0; m_fb[d] <= '0; m_fs[d] <= '0;
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    logic cmp_en = 1'b0;
    always @(negedge clk) begin
        logic [7:0] xa0, xb0, xa1, xb1;
        if (cmp_en) begin
            xa0 = m_busy[0] ? va[0][m_k[0]] : 8'd0;
            xb0 = m_busy[0] ? vb[0][m_k[0]] : 8'd0;
            xa1 = m_busy[1] ? va[1][m_k[1]] : 8'd0;
            xb1 = m_busy[1] ? vb[1][m_k[1]] : 8'd0;
            cmp("dut0_cycle",
                {busy0, done0, pass0, a0, b0, vc0, ec0, fa0, fb0, fs0},
                {m_busy[0], m_done[0], m_pass[0], xa0, xb0, 16'(m_vec[0]), 16'(m_err[0]),
                 m_fa[0], m_fb[0], m_fs[0]});
            cmp("dut1_cycle",
                {busy1, done1, pass1, a1, b1, vc1, ec1, fa1, fb1, fs1},
                {m_busy[1], m_done[1], m_pass[1], xa1, xb1, 16'(m_vec[1]), 16'(m_err[1]),
                 m_fa[1], m_fb[1], m_fs[1]});
        end
    end

    task automatic pulse_start0();
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
    endtask

    // Waits (bounded) for dut0 done; reports cycles after E0 and busy cycles seen.
    task automatic wait_done0(output int cyc, output int busy_cyc);
        cyc = 0; busy_cyc = 0;
        while (cyc < 300 && !done0) begin
            if (busy0) busy_cyc++;
            @(negedge clk); cyc++;
        end
    endtask

    int c, bc;

    initial begin
        logic [31:0] s;
        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; fault = 1'b0;
        ctab = '{16'h0000, 16'h00FF, 16'hFF00, 16'hFFFF, 16'hFF01};
        nvec[0] = NV0; nvec[1] = NV1;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 5; i++) begin
                va[d][i] = ctab[i][15:8]; vb[d][i] = ctab[i][7:0];
            end
            for (int i = 5; i < NV0; i++) begin
                va[d][i] = 8'd0; vb[d][i] = 8'd0;
            end
        end
        s = 32'hACE1_2025;
        for (int i = 5; i < NV0; i++) begin
            va[0][i] = s[7:0]; vb[0][i] = s[15:8];
            s = lfsr_next(s);
        end

        // Reset values.
        repeat (3) @(negedge clk);
        cmp("reset_dut0", {a0, b0, busy0, done0, pass0, vc0, ec0, fa0, fb0, fs0}, '0);
        cmp("reset_dut1", {a1, b1, busy1, done1, pass1, vc1, ec1, fa1, fb1, fs1}, '0);
        cmp_en = 1'b1;
        @(negedge clk); rst_n = 1'b1;

        // Run A: golden adder, start re-pulsed at cycles 10 and 50; dut1 runs corners only.
        @(negedge clk); start0 = 1'b1; start1 = 1'b1;
        @(negedge clk); start0 = 1'b0; start1 = 1'b0;
        c = 0; bc = 0;
        while (c < 300 && !done0) begin
            if (busy0) bc++;
            if (c < 5) cmp("dut1_corner_ops", {a1, b1}, ctab[c]);
            if (c == 5) begin
                cmp("dut0_rand0_seed", {a0, b0}, 16'h2520);
                cmp("dut1_done_after5", {done1, busy1, pass1, vc1, ec1}, {3'b101, 16'd5, 16'd0});
            end
            if (c == 6) cmp("dut0_rand1", {a0, b0}, 16'h4B40);
            start0 = (c == 10 || c == 50);
            @(negedge clk); c++;
        end
        start0 = 1'b0;
        cmp("runA_done_latency", 32'(c), 32'd105);
        cmp("runA_busy_cycles", 32'(bc), 32'd105);
        cmp("runA_result", {done0, pass0, vc0, ec0}, {2'b11, 16'd105, 16'd0});

        // Run B: carry-out stuck at 0, restarted from DONE.
        fault = 1'b1;
        pulse_start0();
        wait_done0(c, bc);
        cmp("runB_first_fail", {fa0, fb0, fs0}, {8'd255, 8'd255, 9'h0FE});
        cmp("runB_err_ge2", 32'(ec0 >= 16'd2), 32'd1);
        cmp("runB_result", {done0, pass0, vc0}, {2'b10, 16'd105});
        fault = 1'b0;

        // Run C: reset asserted mid-run, then a fresh run.
        pulse_start0();
        repeat (40) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 cmp("runC_async_reset", {a0, b0, busy0, done0, pass0, vc0, ec0, fa0, fb0, fs0}, '0);
        @(negedge clk); rst_n = 1'b1;
        pulse_start0();
        wait_done0(c, bc);
        cmp("runC_busy_cycles", 32'(bc), 32'd105);
        cmp("runC_result", {done0, pass0, vc0, ec0}, {2'b11, 16'd105, 16'd0});

        repeat (2) @(negedge clk);
        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/adder_stim_checker.md
# adder_stim_checker

Self-checking traffic source for the combinational `simple_adder` (operands `a`, `b` of WIDTH bits; `sum` of WIDTH+1 bits). It drives operand vectors into the adder and samples the returned sum one cycle later. It compares each sum against an internally computed expected value, then reports pass/fail, error counts and the first failing vector. It sits beside the adder in the ALU TDD harness so the protocol can be exercised on silicon/FPGA without a simulator testbench.

## Interface
- WIDTH, 8: operand width; legal range 2..16.
- NUM_RANDOM, 100: pseudo-random vectors issued after the corner set; legal range 0..65530.
- LFSR_SEED, 32'hACE1_2025: LFSR load value; must be nonzero.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle run request.
- op_a  out  WIDTH  operand to adder `a`.
- op_b  out  WIDTH  operand to adder `b`.
- sum_in  in  WIDTH+1  adder `sum`, combinational from op_a/op_b.
- busy  out  1  run in progress.
- done  out  1  run complete, held until next start or reset.
- pass  out  1  done and error_count==0.
- vec_count  out  16  vectors checked this run.
- error_count  out  16  mismatches, saturating at 16'hFFFF.
- fail_a, fail_b  out  WIDTH  operands of first mismatch.
- fail_sum  out  WIDTH+1  sum_in captured at first mismatch.

## Operation
- States: IDLE, CORNER, RANDOM, DONE.
- IDLE: `start` → clear counters/fail regs, load LFSR with seed, load corner vector 0, go to CORNER.
- CORNER: issue 5 vectors, one per cycle, in this order:
  - 0+0
  - 0+MAX
  - MAX+0
  - MAX+MAX
  - MAX+1
  - MAX = 2^WIDTH−1.
  - After the 5th vector: go to RANDOM, or to DONE if NUM_RANDOM==0.
- RANDOM: NUM_RANDOM vectors.
  - op_a = lfsr[WIDTH−1:0], op_b = lfsr[2*WIDTH−1:WIDTH].
  - LFSR steps once per vector.
  - The first random vector uses the seed value.
  - LFSR is 32-bit Fibonacci, polynomial x^32+x^22+x^2+x+1.
- Check: each edge while a vector is outstanding:
  - expected = {1'b0,op_a} + {1'b0,op_b}, computed at WIDTH+1 bits (no truncation).
  - Mismatch uses 4-state inequality in simulation: X/Z on sum_in counts as an error.
  - vec_count increments for every vector checked.
  - On mismatch, error_count increments.
  - On the first mismatch, fail_a/fail_b/fail_sum are captured and then frozen.
- DONE: op_a/op_b = 0, busy=0, done=1.
  - pass = (error_count==0).
  - `start` restarts exactly as from IDLE.
- `start` while busy: ignored.
- Reset values: every output 0, state IDLE.
- Reset mid-run: asynchronous return to IDLE with all outputs 0; no partial results are retained.

## Timing
- Edge E0 samples start=1 and loads vector v0; busy rises after E0.
- Edge Ek (k≥1):
  - samples sum_in for v(k−1), which has been stable for the full preceding cycle;
  - loads vk.
- N = 5+NUM_RANDOM vectors.
  - Edge EN checks the final vector, enters DONE, and asserts done/pass.
  - busy is high for exactly N cycles.
- Combinational adder path budget: one full clock period op_a/op_b → sum_in.
- Counters and fail registers update on the same edge as the check.

## Structure
- Package `adder_check_pkg` holds:
  - state enum `chk_state_t`;
  - corner-count constant 5;
  - LFSR tap mask;
  - default seed.
- Sub-module `adder_lfsr32`: load, step enable and 32-bit state output.
- The FSM, check, counters and capture logic stay in the top module.

## Test plan
- Reset: hold rst_n=0 → op_a=op_b=0, busy=done=pass=0, vec_count=error_count=0.
- Golden `simple_adder` (WIDTH=8, NUM_RANDOM=100), pulse start:
  - busy high 105 cycles;
  - done=1, pass=1;
  - vec_count=105, error_count=0.
- Faulty adder with sum[8] stuck 0:
  - first failure fail_a=255, fail_b=255, fail_sum=9'h0FE;
  - 255+1 also fails;
  - pass=0, error_count≥2.
- start re-pulsed at cycles 10 and 50 of a run → ignored; done still arrives 105 cycles after the original start; vec_count=105.
- rst_n pulsed low at cycle 40 → outputs 0 immediately; after release and a new start, the run completes with vec_count=105, error_count=0.
- NUM_RANDOM=0:
  - op_a/op_b sequence (0,0), (0,255), (255,0), (255,255), (255,1);
  - done 5 cycles after start, vec_count=5.
